// File: rtl/pwm_duty_meter.sv
// Measures period and high time of an asynchronous PWM input in clock cycles.
// One result per full period with a VALID strobe; STUCK flags a missing rising edge.
module pwm_duty_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK_50M,
    input  logic             RST,
    input  logic             PWM_IN,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_TIME,
    output logic             VALID,
    output logic             STUCK,
    output logic             STUCK_LEVEL,
    output logic             STATE_DBG
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_d_q;
    logic [CNT_W-1:0]       pcnt_q, pcnt_d;
    logic [CNT_W-1:0]       hcnt_q, hcnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic                   valid_q, valid_d;
    logic                   stuck_q, stuck_d;
    logic                   stuck_level_q, stuck_level_d;

    logic pwm_s;
    logic rise;
    logic timeout;
    logic result_en;

    assign pwm_s   = sync_q[SYNC_STAGES-1];
    assign rise    = pwm_s & ~pwm_d_q;
    // A rise in the saturation cycle wins over the timeout.
    assign timeout = (pcnt_q == SAT) && !rise;

    always_ff @(posedge CLK_50M or negedge RST) begin
        if (!RST) begin
            state_q       <= S_IDLE;
            sync_q        <= '0;
            pwm_d_q       <= 1'b0;
            pcnt_q        <= '0;
            hcnt_q        <= '0;
            period_q      <= '0;
            high_q        <= '0;
            valid_q       <= 1'b0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= {sync_q[SYNC_STAGES-2:0], PWM_IN};
            pwm_d_q       <= pwm_s;
            pcnt_q        <= pcnt_d;
            hcnt_q        <= hcnt_d;
            period_q      <= period_d;
            high_q        <= high_d;
            valid_q       <= valid_d;
            stuck_q       <= stuck_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (rise) state_d = S_MEASURE;
            S_MEASURE: if (timeout) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        result_en = (state_q == S_MEASURE) && rise;

        pcnt_d = pcnt_q;
        hcnt_d = hcnt_q;
        if (rise) begin
            pcnt_d = ONE;
            hcnt_d = ONE;
        end else begin
            if (pcnt_q != SAT) pcnt_d = pcnt_q + ONE;
            if (pwm_s && (hcnt_q != SAT)) hcnt_d = hcnt_q + ONE;
        end

        period_d      = result_en ? pcnt_q : period_q;
        high_d        = result_en ? hcnt_q : high_q;
        valid_d       = result_en;
        stuck_d       = stuck_q;
        stuck_level_d = stuck_level_q;
        if (result_en) begin
            stuck_d = 1'b0;
        end else if (timeout) begin
            stuck_d = 1'b1;
            // Saturation persists while stuck; keep the level seen when STUCK first set.
            if (!stuck_q) stuck_level_d = pwm_s;
        end
    end

    assign PERIOD      = period_q;
    assign HIGH_TIME   = high_q;
    assign VALID       = valid_q;
    assign STUCK       = stuck_q;
    assign STUCK_LEVEL = stuck_level_q;
    assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter (CNT_W=8): driver pushes expected results,
// a negedge monitor pops and compares them on every VALID.
module tb_pwm_duty_meter;

    localparam int W   = 8;
    localparam int SAT = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pwm_in = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         stuck;
    logic         stuck_level;
    logic         state_dbg;

    pwm_duty_meter #(.CNT_W(W), .SYNC_STAGES(2)) dut (
        .CLK_50M    (clk),
        .RST        (rst_n),
        .PWM_IN     (pwm_in),
        .PERIOD     (period),
        .HIGH_TIME  (high_time),
        .VALID      (valid),
        .STUCK      (stuck),
        .STUCK_LEVEL(stuck_level),
        .STATE_DBG  (state_dbg)
    );

    always #5 clk = ~clk;

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [2*W-1:0] exp_q[$];

    // Waveform model: cycles since the last driven rising edge and how many were high.
    int m_len   = 0;
    int m_high  = 0;
    bit m_armed = 1'b0;
    bit cur_lv  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit lv, input int n);
        if (lv && !cur_lv) begin
            if (m_armed && m_len <= SAT)
                exp_q.push_back({m_len[W-1:0], m_high[W-1:0]});
            m_armed = 1'b1;
            m_len   = 0;
            m_high  = 0;
        end
        cur_lv = lv;
        pwm_in = lv;
        repeat (n) @(negedge clk);
        m_len += n;
        if (lv) m_high += n;
    endtask

    task automatic stream(input int h, input int l, input int n);
        repeat (n) begin
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        if (rst_n && valid) begin
            check("valid_spacing", prev_valid, 0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got period %0d high %0d, expected no result",
                         period, high_time);
            end else begin
                e = exp_q.pop_front();
                check("period", period, e[2*W-1:W]);
                check("high_time", high_time, e[W-1:0]);
                check("stuck_on_valid", stuck, 0);
            end
        end
        prev_valid = valid;
    end

    initial begin
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_stuck", stuck, 0);
        check("rst_stuck_level", stuck_level, 0);
        check("rst_state", state_dbg, 0);
        rst_n = 1'b1;

        stream(32, 32, 6);
        stream(10, 90, 4);
        stream(1, 2, 6);
        stream(1, 1, 6);
        check("no_stuck_in_streams", stuck, 0);

        // Hold high after a 50-cycle stream until the timeout fires.
        stream(25, 25, 4);
        drive(1'b1, 257);
        check("stuck_before_timeout", stuck, 0);
        drive(1'b1, 1);
        check("stuck_after_timeout", stuck, 1);
        check("stuck_level_high", stuck_level, 1);
        check("period_held", period, 50);
        check("high_held", high_time, 25);
        check("state_idle_after_timeout", state_dbg, 0);
        drive(1'b1, 20);
        drive(1'b0, 25);
        drive(1'b1, 25);
        check("stuck_after_first_rise", stuck, 1);
        check("state_armed", state_dbg, 1);
        drive(1'b0, 25);
        stream(25, 25, 3);
        check("stuck_cleared", stuck, 0);

        // Rise exactly on saturation.
        drive(1'b1, 10);
        drive(1'b0, 245);
        drive(1'b1, 10);
        drive(1'b0, 20);
        check("stuck_after_sat_rise", stuck, 0);
        check("period_sat", period, 255);

        // Asynchronous reset mid-period, input low.
        check("queue_drained_before_reset", exp_q.size(), 0);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_period", period, 0);
        check("mid_rst_high", high_time, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_stuck", stuck, 0);
        check("mid_rst_stuck_level", stuck_level, 0);
        check("mid_rst_state", state_dbg, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_armed = 1'b0;
        m_len   = 0;
        m_high  = 0;
        stream(20, 30, 4);
        drive(1'b0, 40);
        check("queue_drained_at_end", exp_q.size(), 0);
        check("final_period", period, 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
